// File: rtl/gate_chk_pkg.sv
// Shared types and widths for the gate response checker.
package gate_chk_pkg;

  localparam int VEC_W = 6;
  localparam int OBS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Golden response of the gate circuit under test: y1 = a ^ (c|d|e), y2 = ~b & (c|d|e) & f.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [VEC_W-1:0] vec_in,
  output logic [OBS_W-1:0] y_exp
);

  logic or3;

  assign or3      = vec_in[3] | vec_in[2] | vec_in[1];
  assign y_exp[1] = vec_in[5] ^ or3;
  assign y_exp[0] = ~vec_in[4] & or3 & vec_in[0];

endmodule

// File: rtl/gate_response_checker.sv
// Session-based checker comparing observed gate responses against the reference model.
// Optional first-failure capture is enabled with GATE_CHK_FAIL_LOG_EN.
//
// state | meaning
// IDLE  | no session yet since reset; vectors ignored
// RUN   | session open; each vec_valid cycle is checked and counted
// DONE  | session closed; counters and pass held until the next start
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int VEC_CNT_W = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 vec_valid,
  input  logic [VEC_W-1:0]     vec_in,
  input  logic [OBS_W-1:0]     y_obs,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [VEC_CNT_W-1:0] vec_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [VEC_W-1:0]     fail_vec,
  output logic [OBS_W-1:0]     fail_obs
);

  chk_state_e       state;
  chk_state_e       state_nxt;
  logic             clear;
  logic             sample;
  logic             miss;
  logic [OBS_W-1:0] y_exp;

  gate_ref_model u_ref (
    .vec_in (vec_in),
    .y_exp  (y_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A vector presented alongside stop is still part of the session.
  assign sample = (state == RUN) && vec_valid;
  assign miss   = sample && (y_obs != y_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt  <= '0;
      err_cnt  <= '0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= miss;
      if (clear) begin
        vec_cnt <= '0;
        err_cnt <= '0;
      end else begin
        if (sample && (vec_cnt != '1)) begin
          vec_cnt <= vec_cnt + VEC_CNT_W'(1);
        end
        if (miss && (err_cnt != '1)) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

`ifdef GATE_CHK_FAIL_LOG_EN
  logic [VEC_W-1:0] fail_vec_q;
  logic [OBS_W-1:0] fail_obs_q;

  // err_cnt never returns to zero inside a session, so zero marks the first miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec_q <= '0;
      fail_obs_q <= '0;
    end else if (clear) begin
      fail_vec_q <= '0;
      fail_obs_q <= '0;
    end else if (miss && (err_cnt == '0)) begin
      fail_vec_q <= vec_in;
      fail_obs_q <= y_obs;
    end
  end

  assign fail_vec = fail_vec_q;
  assign fail_obs = fail_obs_q;
`else
  assign fail_vec = '0;
  assign fail_obs = '0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0) && (vec_cnt != '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized bench for gate_response_checker against a session-level reference model.
// Two instances share stimulus: default widths and 4-bit counters for saturation.
module tb_gate_response_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       vec_valid;
  logic [5:0] vec_in;
  logic [1:0] y_obs;

  logic       busy, done, pass, mismatch;
  logic [7:0] vec_cnt, err_cnt;
  logic [5:0] fail_vec;
  logic [1:0] fail_obs;

  logic       busy_n, done_n, pass_n, mismatch_n;
  logic [3:0] vec_cnt_n, err_cnt_n;
  logic [5:0] fail_vec_n;
  logic [1:0] fail_obs_n;

  int n_chk;
  int n_err;

  // model state: session bookkeeping with unbounded counts
  bit       m_open;
  bit       m_closed;
  int       m_vec;
  int       m_err;
  bit       m_mis;
  bit [5:0] m_fail_vec;
  bit [1:0] m_fail_obs;

  gate_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .vec_valid(vec_valid), .vec_in(vec_in), .y_obs(y_obs),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .fail_vec(fail_vec), .fail_obs(fail_obs)
  );

  gate_response_checker #(.VEC_CNT_W(4), .ERR_CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .vec_valid(vec_valid), .vec_in(vec_in), .y_obs(y_obs),
    .busy(busy_n), .done(done_n), .pass(pass_n), .mismatch(mismatch_n),
    .vec_cnt(vec_cnt_n), .err_cnt(err_cnt_n),
    .fail_vec(fail_vec_n), .fail_obs(fail_obs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [1:0] ref_y(input bit [5:0] v);
    int  hits;
    bit  or3, y1, y2;
    hits = int'(v[3]) + int'(v[2]) + int'(v[1]);
    or3  = (hits > 0);
    y1   = (v[5] != or3);
    y2   = (!v[4]) && or3 && v[0];
    return {y1, y2};
  endfunction

  function automatic int sat(input int val, input int w);
    int top;
    top = (1 << w) - 1;
    return (val > top) ? top : val;
  endfunction

  task automatic model_reset();
    m_open = 0; m_closed = 0; m_vec = 0; m_err = 0; m_mis = 0;
    m_fail_vec = '0; m_fail_obs = '0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit v, input bit [5:0] vi, input bit [1:0] yo);
    m_mis = 0;
    if (m_open) begin
      if (v) begin
        m_vec++;
        if (yo != ref_y(vi)) begin
          m_mis = 1;
          if (m_err == 0) begin
            m_fail_vec = vi;
            m_fail_obs = yo;
          end
          m_err++;
        end
      end
      if (p) begin
        m_open   = 0;
        m_closed = 1;
      end
    end else if (s) begin
      m_open = 1; m_closed = 0; m_vec = 0; m_err = 0;
      m_fail_vec = '0; m_fail_obs = '0;
    end
  endtask

  task automatic check_all(input string ph);
    bit [5:0] efv;
    bit [1:0] efo;
`ifdef GATE_CHK_FAIL_LOG_EN
    efv = m_fail_vec;
    efo = m_fail_obs;
`else
    efv = '0;
    efo = '0;
`endif
    chk({ph, ".busy"}, 32'(busy), 32'(m_open));
    chk({ph, ".done"}, 32'(done), 32'(m_closed));
    chk({ph, ".pass"}, 32'(pass), 32'(m_closed && m_err == 0 && m_vec != 0));
    chk({ph, ".mismatch"}, 32'(mismatch), 32'(m_mis));
    chk({ph, ".vec_cnt"}, 32'(vec_cnt), 32'(sat(m_vec, 8)));
    chk({ph, ".err_cnt"}, 32'(err_cnt), 32'(sat(m_err, 8)));
    chk({ph, ".fail_vec"}, 32'(fail_vec), 32'(efv));
    chk({ph, ".fail_obs"}, 32'(fail_obs), 32'(efo));
    chk({ph, ".n_pass"}, 32'(pass_n), 32'(m_closed && m_err == 0 && m_vec != 0));
    chk({ph, ".n_mismatch"}, 32'(mismatch_n), 32'(m_mis));
    chk({ph, ".n_vec_cnt"}, 32'(vec_cnt_n), 32'(sat(m_vec, 4)));
    chk({ph, ".n_err_cnt"}, 32'(err_cnt_n), 32'(sat(m_err, 4)));
  endtask

  task automatic step(input string ph, input bit s, input bit p, input bit v, input bit [5:0] vi, input bit [1:0] yo);
    start = s; stop = p; vec_valid = v; vec_in = vi; y_obs = yo;
    @(posedge clk);
    model_edge(s, p, v, vi, yo);
    #1;
    check_all(ph);
    start = 0; stop = 0; vec_valid = 0;
  endtask

  task automatic good_vec(input string ph, input bit p);
    bit [5:0] vi;
    vi = 6'($urandom_range(0, 63));
    step(ph, 0, p, 1, vi, ref_y(vi));
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 0; start = 0; stop = 0; vec_valid = 0; vec_in = '0; y_obs = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // twelve correct vectors
    step("s1_start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 12; i++) good_vec("s1_vec", 0);
    step("s1_stop", 0, 1, 0, '0, '0);
    chk("s1_vec_cnt", 32'(vec_cnt), 32'd12);
    chk("s1_pass", 32'(pass), 32'd1);

    // first failure then passing vectors
    step("s2_start", 1, 0, 0, '0, '0);
    step("s2_bad", 0, 0, 1, 6'b000001, 2'b01);
    chk("s2_mismatch", 32'(mismatch), 32'd1);
    step("s2_ok1", 0, 0, 1, 6'b101101, 2'b01);
    chk("s2_mis_clear", 32'(mismatch), 32'd0);
    step("s2_ok2", 0, 0, 1, 6'b011011, 2'b10);
    step("s2_stop", 0, 1, 0, '0, '0);
    chk("s2_err_cnt", 32'(err_cnt), 32'd1);
    chk("s2_pass", 32'(pass), 32'd0);
`ifdef GATE_CHK_FAIL_LOG_EN
    chk("s2_fail_vec", 32'(fail_vec), 32'h01);
    chk("s2_fail_obs", 32'(fail_obs), 32'h1);
`else
    chk("s2_fail_vec", 32'(fail_vec), 32'h00);
    chk("s2_fail_obs", 32'(fail_obs), 32'h0);
`endif
    step("s2_idle_vec", 0, 0, 1, 6'b000001, 2'b11);

    // saturation of the narrow instance
    step("s3_start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) good_vec("s3_vec", 0);
    chk("s3_sat", 32'(vec_cnt_n), 32'd15);
    step("s3_stop", 0, 1, 0, '0, '0);
    chk("s3_sat_hold", 32'(vec_cnt_n), 32'd15);
    chk("s3_wide", 32'(vec_cnt), 32'd20);

    // stop coincident with fifth vector; stop in DONE ignored
    step("s4_start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) good_vec("s4_vec", 0);
    good_vec("s4_last", 1);
    chk("s4_vec_cnt", 32'(vec_cnt), 32'd5);
    chk("s4_done", 32'(done), 32'd1);
    step("s4_stop_again", 0, 1, 1, 6'h3f, 2'b00);

    // asynchronous reset mid-session
    step("s5_start", 1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) good_vec("s5_vec", 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all("s5_rst_async");
    @(posedge clk); #1;
    check_all("s5_rst_hold");
    rst_n = 1;
    step("s5_ignored", 0, 0, 1, 6'b000001, 2'b11);
    step("s5_ignored2", 0, 0, 1, 6'b111111, 2'b00);
    chk("s5_vec_cnt", 32'(vec_cnt), 32'd0);

    // empty session then restart from DONE
    step("s6_start", 1, 0, 0, '0, '0);
    step("s6_stop", 0, 1, 0, '0, '0);
    chk("s6_pass", 32'(pass), 32'd0);
    step("s6_restart", 1, 0, 0, '0, '0);
    chk("s6_busy", 32'(busy), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit       s, p, v;
      bit [5:0] vi;
      bit [1:0] yo;
      s  = ($urandom_range(0, 99) < 6);
      p  = ($urandom_range(0, 99) < 5);
      v  = ($urandom_range(0, 99) < 65);
      vi = 6'($urandom_range(0, 63));
      yo = ($urandom_range(0, 99) < 80) ? ref_y(vi) : 2'($urandom_range(0, 3));
      step("rand", s, p, v, vi, yo);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL have parameter VEC_CNT_W, default 8, giving the width of the applied-vector counter.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, giving the width of the mismatch counter.
REQ-003 SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that opens a check session.
- stop  input  1  one-cycle pulse that closes the session.
- vec_valid  input  1  vec_in/y_obs hold a settled vector this cycle.
- vec_in  input  6  applied stimulus {a,b,c,d,e,f}, a = MSB.
- y_obs  input  2  observed gate-circuit response {y1,y2}, y1 = MSB.
- busy  output  1  session in progress.
- done  output  1  session closed; results stable.
- pass  output  1  done with zero mismatches and at least one vector.
- mismatch  output  1  one-cycle pulse, previous sampled vector failed.
- vec_cnt  output  VEC_CNT_W  vectors sampled this session.
- err_cnt  output  ERR_CNT_W  mismatching vectors this session.
- fail_vec  output  6  first failing vec_in (macro-dependent).
- fail_obs  output  2  y_obs of first failing vector (macro-dependent).

Function
REQ-004 SHALL compute expected response combinationally: or3 = c|d|e; y1_exp = a ^ or3; y2_exp = ~b & or3 & f.
REQ-005 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-006 IDLE: start -> RUN, clearing vec_cnt, err_cnt, fail_vec, fail_obs on the same edge.
REQ-007 RUN: each vec_valid cycle SHALL compare y_obs to {y1_exp,y2_exp}; vec_cnt increments, and on inequality err_cnt increments and mismatch pulses, all visible one cycle after sampling.
REQ-008 RUN: stop -> DONE; a vec_valid in the same cycle as stop SHALL still be sampled and counted.
REQ-009 RUN: start SHALL be ignored; no counter clear.
REQ-010 DONE: start -> RUN with counter clear as in REQ-006; otherwise DONE holds all results.
REQ-011 vec_valid outside RUN SHALL be ignored; mismatch stays 0.
REQ-012 vec_cnt and err_cnt SHALL saturate at all-ones, no wrap.
REQ-013 pass SHALL be 1 only in DONE with err_cnt==0 and vec_cnt!=0; otherwise 0.
REQ-014 stop in IDLE or DONE SHALL be ignored.

Reset
REQ-015 rst_n low SHALL asynchronously force state IDLE and busy, done, pass, mismatch, vec_cnt, err_cnt, fail_vec, fail_obs to 0, including mid-session; session data is discarded.

Configuration
REQ-016 With GATE_CHK_FAIL_LOG_EN defined, fail_vec/fail_obs SHALL capture vec_in/y_obs of the first mismatch in a session and hold until cleared by start or reset.
REQ-017 Without GATE_CHK_FAIL_LOG_EN, fail_vec and fail_obs SHALL be tied to 0 and no capture registers SHALL exist.

Structure
REQ-018 Package gate_chk_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and constants VEC_W=6, OBS_W=2.
REQ-019 Expected-response logic SHALL be a sub-module gate_ref_model (vec_in -> y_exp[1:0]), purely combinational.

Verification
REQ-020 Bench SHALL cover:
- start, 12 correct vectors, stop -> vec_cnt=12, err_cnt=0, done=1, pass=1.
- vec_in=6'b000001 with y_obs=2'b01 (expected 00) -> mismatch pulse next cycle, err_cnt=1, fail_vec=6'b000001, fail_obs=2'b01 (macro on) / 0 (macro off); later vec 6'b101101/y_obs=2'b01 and 6'b011011/y_obs=2'b10 pass, err_cnt stays 1, pass=0.
- VEC_CNT_W=4, 20 correct vectors -> vec_cnt=15, stays 15.
- vec_valid and stop in same cycle on 5th vector -> vec_cnt=5, done=1.
- rst_n low for 1 cycle after 3 vectors in RUN -> all outputs 0, IDLE; subsequent vec_valid ignored until start.
- start, stop with no vectors -> done=1, pass=0; start again from DONE -> counters 0, busy=1.
